// File: rtl/hyper_pipe_af_sink_if.sv
// Avalon-ST stream seen by hyper_pipe_af_sink: an almost_full-controlled input side
// and a ready/valid output side.
interface hyper_pipe_af_sink_if #(
   parameter int DATA_WIDTH  = 512,
   parameter int EMPTY_WIDTH = 6
);
   logic                   in_sop;
   logic                   in_eop;
   logic [DATA_WIDTH-1:0]  in_data;
   logic [EMPTY_WIDTH-1:0] in_empty;
   logic                   in_valid;
   logic                   out_almost_full;
   logic                   out_sop;
   logic                   out_eop;
   logic [DATA_WIDTH-1:0]  out_data;
   logic [EMPTY_WIDTH-1:0] out_empty;
   logic                   out_valid;
   logic                   out_ready;

   modport master (
      output in_sop, in_eop, in_data, in_empty, in_valid, out_ready,
      input  out_almost_full, out_sop, out_eop, out_data, out_empty, out_valid
   );

   modport slave (
      input  in_sop, in_eop, in_data, in_empty, in_valid, out_ready,
      output out_almost_full, out_sop, out_eop, out_data, out_empty, out_valid
   );
endinterface

// File: rtl/hyper_pipe_af_sink.sv
// Receive endpoint for hyper_pipe'd Avalon-ST: FWFT FIFO that absorbs in-flight beats,
// raises almost_full early enough for the pipe round trip, checks framing and counts drops.
module hyper_pipe_af_sink #(
   parameter int DATA_WIDTH  = 512,
   parameter int EMPTY_WIDTH = 6,
   parameter int DEPTH       = 16,
   parameter int NUM_PIPES   = 1,
   parameter int AF_THRESH   = DEPTH - (2 * NUM_PIPES + 2)
) (
   input  logic                   clk,
   input  logic                   rst,
   hyper_pipe_af_sink_if.slave    st,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   overflow,
   output logic                   framing_err,
   output logic [31:0]            drop_cnt
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam int ENT_W = DATA_WIDTH + EMPTY_WIDTH + 2;
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] AF_OCC   = OCC_W'(AF_THRESH);

   typedef enum logic {S_IDLE, S_IN_PKT} frame_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [ENT_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;
   logic [OCC_W-1:0] w_occ_nxt;
   logic             r_af;
   logic             r_overflow;
   logic             r_framing_err;
   logic [31:0]      r_drop_cnt;
   frame_t           r_frame;
   frame_t           w_frame_nxt;
   logic             w_frame_err;
   logic             w_full;
   logic             w_out_valid;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [ENT_W-1:0] w_head;

   assign w_full      = (r_occ == FULL_OCC);
   assign w_out_valid = (r_occ != '0);
   assign w_pop       = w_out_valid & st.out_ready;
   // A full FIFO still accepts a beat when the head leaves in the same cycle.
   assign w_push      = st.in_valid & (~w_full | w_pop);
   assign w_drop      = st.in_valid & w_full & ~w_pop;

   always_comb begin
      w_occ_nxt = r_occ;
      case ({w_push, w_pop})
         2'b10:   w_occ_nxt = r_occ + OCC_W'(1);
         2'b01:   w_occ_nxt = r_occ - OCC_W'(1);
         default: w_occ_nxt = r_occ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {st.in_sop, st.in_eop, st.in_empty, st.in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_af     <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_occ <= w_occ_nxt;
         r_af  <= (w_occ_nxt >= AF_OCC);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow    <= 1'b0;
         r_framing_err <= 1'b0;
         r_drop_cnt    <= '0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= sat_inc32(r_drop_cnt);
         end
         if (w_frame_err) r_framing_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_frame <= S_IDLE;
      else     r_frame <= w_frame_nxt;
   end

   // Framing is tracked on every presented beat, including ones that end up dropped.
   always_comb begin
      w_frame_nxt = r_frame;
      w_frame_err = 1'b0;
      if (st.in_valid) begin
         case (r_frame)
            S_IDLE: begin
               if (!st.in_sop)      w_frame_err = 1'b1;
               else if (!st.in_eop) w_frame_nxt = S_IN_PKT;
            end
            S_IN_PKT: begin
               if (st.in_sop)       w_frame_err = 1'b1;
               else if (st.in_eop)  w_frame_nxt = S_IDLE;
            end
            default: w_frame_nxt = S_IDLE;
         endcase
      end
   end

   assign w_head             = r_mem[r_rd_ptr];
   assign st.out_sop         = w_head[ENT_W-1];
   assign st.out_eop         = w_head[ENT_W-2];
   assign st.out_empty       = w_head[DATA_WIDTH +: EMPTY_WIDTH];
   assign st.out_data        = w_head[DATA_WIDTH-1:0];
   assign st.out_valid       = w_out_valid;
   assign st.out_almost_full = r_af;

   assign occupancy   = r_occ;
   assign overflow    = r_overflow;
   assign framing_err = r_framing_err;
   assign drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_hyper_pipe_af_sink.sv
// Bench for hyper_pipe_af_sink: directed scenarios plus a randomized run against a
// queue-based reference model.
module tb_hyper_pipe_af_sink;
   localparam int DW    = 512;
   localparam int EW    = 6;
   localparam int DEPTH = 16;
   localparam int NP    = 1;
   localparam int AF    = DEPTH - (2 * NP + 2);

   typedef struct packed {
      logic          sop;
      logic          eop;
      logic [EW-1:0] empty;
      logic [DW-1:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  occupancy;
   logic        overflow;
   logic        framing_err;
   logic [31:0] drop_cnt;

   hyper_pipe_af_sink_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) st ();

   hyper_pipe_af_sink #(
      .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .DEPTH(DEPTH), .NUM_PIPES(NP)
   ) dut (
      .clk(clk), .rst(rst), .st(st),
      .occupancy(occupancy), .overflow(overflow),
      .framing_err(framing_err), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   beat_t       mq[$];
   bit          m_af, m_ovf, m_ferr, m_inpkt;
   logic [31:0] m_drop;
   int          total = 0;
   int          bad   = 0;

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic set_in(input logic v, input logic sop, input logic eop,
                         input logic [EW-1:0] emp, input logic [DW-1:0] d);
      st.in_valid = v;
      st.in_sop   = sop;
      st.in_eop   = eop;
      st.in_empty = emp;
      st.in_data  = d;
   endtask

   // Reference: the FIFO is a queue, occupancy its size, plus packet-state and drop bookkeeping.
   task automatic model_edge();
      bit    pop, full;
      beat_t b;
      if (rst) begin
         mq.delete();
         m_af = 0; m_ovf = 0; m_ferr = 0; m_inpkt = 0; m_drop = 0;
      end else begin
         pop  = (mq.size() != 0) && st.out_ready;
         full = (mq.size() == DEPTH);
         b    = '{st.in_sop, st.in_eop, st.in_empty, st.in_data};
         if (st.in_valid) begin
            if (!m_inpkt) begin
               if (!b.sop) m_ferr = 1;
               else if (!b.eop) m_inpkt = 1;
            end else begin
               if (b.sop) m_ferr = 1;
               else if (b.eop) m_inpkt = 0;
            end
         end
         if (pop) void'(mq.pop_front());
         if (st.in_valid) begin
            if (!full || pop) mq.push_back(b);
            else begin
               m_ovf = 1;
               if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
            end
         end
         m_af = (mq.size() >= AF);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(1'b1, 1'b0, 1'b0, 6'd3, rand_data());
      tick();
      tick();
      rst = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_reset();
      st.out_ready = 1'b1;
      do_reset();
      total++;
      if ({st.out_valid, st.out_almost_full, overflow, framing_err} !== 4'b0) begin
         bad++;
         $display("FAIL reset_flags: got v/af/ovf/ferr=%b want 0000",
                  {st.out_valid, st.out_almost_full, overflow, framing_err});
      end
      total++;
      if (occupancy !== 5'd0) begin
         bad++; $display("FAIL reset_occ: got %0d want 0", occupancy);
      end
      total++;
      if (drop_cnt !== 32'd0) begin
         bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
      end
   endtask

   task automatic test_single_beat();
      logic [DW-1:0] d;
      d = {(DW/8){8'hA5}};
      do_reset();
      st.out_ready = 1'b1;
      set_in(1'b1, 1'b1, 1'b1, 6'd5, d);
      tick();
      set_in(1'b0, 1'b0, 1'b0, '0, '0);
      total++;
      if (st.out_valid !== 1'b1 || occupancy !== 5'd1) begin
         bad++; $display("FAIL single_valid: got v=%b occ=%0d want v=1 occ=1", st.out_valid, occupancy);
      end
      total++;
      if ({st.out_sop, st.out_eop, st.out_empty, st.out_data} !== {1'b1, 1'b1, 6'd5, d}) begin
         bad++; $display("FAIL single_fields: got sop=%b eop=%b empty=%0d data=%h",
                         st.out_sop, st.out_eop, st.out_empty, st.out_data);
      end
      tick();
      total++;
      if (occupancy !== 5'd0 || st.out_valid !== 1'b0) begin
         bad++; $display("FAIL single_drain: got occ=%0d v=%b want 0 0", occupancy, st.out_valid);
      end
   endtask

   task automatic test_almost_full();
      do_reset();
      st.out_ready = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         set_in(1'b1, (i == 1), 1'b0, '0, DW'(i));
         tick();
         total++;
         if (st.out_almost_full !== (i >= AF)) begin
            bad++; $display("FAIL af_beat%0d: got af=%b want %b", i, st.out_almost_full, (i >= AF));
         end
      end
      set_in(1'b0, 1'b0, 1'b0, '0, '0);
      total++;
      if (occupancy !== 5'd15 || drop_cnt !== 32'd0 || overflow !== 1'b0) begin
         bad++; $display("FAIL af_stop: got occ=%0d drop=%0d ovf=%b want 15 0 0", occupancy, drop_cnt, overflow);
      end
   endtask

   task automatic test_overflow();
      set_in(1'b1, 1'b0, 1'b1, '0, DW'(16));
      tick();
      total++;
      if (occupancy !== 5'd16) begin
         bad++; $display("FAIL ovf_fill: got occ=%0d want 16", occupancy);
      end
      set_in(1'b1, 1'b1, 1'b1, '0, DW'(17));
      tick();
      set_in(1'b0, 1'b0, 1'b0, '0, '0);
      total++;
      if (overflow !== 1'b1 || drop_cnt !== 32'd1 || occupancy !== 5'd16) begin
         bad++; $display("FAIL ovf_drop: got ovf=%b drop=%0d occ=%0d want 1 1 16", overflow, drop_cnt, occupancy);
      end
      total++;
      if (st.out_data !== DW'(1) || st.out_sop !== 1'b1 || framing_err !== 1'b0) begin
         bad++; $display("FAIL ovf_head: got data=%0d sop=%b ferr=%b want 1 1 0", st.out_data, st.out_sop, framing_err);
      end
   endtask

   task automatic test_full_pop();
      logic [DW-1:0] exp;
      set_in(1'b1, 1'b1, 1'b1, '0, DW'(18));
      st.out_ready = 1'b1;
      tick();
      set_in(1'b0, 1'b0, 1'b0, '0, '0);
      st.out_ready = 1'b0;
      total++;
      if (occupancy !== 5'd16 || drop_cnt !== 32'd1 || st.out_data !== DW'(2)) begin
         bad++; $display("FAIL full_pop: got occ=%0d drop=%0d head=%0d want 16 1 2", occupancy, drop_cnt, st.out_data);
      end
      st.out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         exp = (k < 15) ? DW'(k + 2) : DW'(18);
         total++;
         if (st.out_valid !== 1'b1 || st.out_data !== exp) begin
            bad++; $display("FAIL full_drain%0d: got v=%b data=%0d want 1 %0d", k, st.out_valid, st.out_data, exp);
         end
         tick();
      end
      total++;
      if (occupancy !== 5'd0) begin
         bad++; $display("FAIL full_drain_end: got occ=%0d want 0", occupancy);
      end
   endtask

   task automatic test_wrap_order();
      int n_sent = 0;
      int n_recv = 0;
      do_reset();
      for (int cyc = 0; cyc < 2000 && n_recv < 40; cyc++) begin
         st.out_ready = 1'($urandom_range(0, 1));
         if (n_sent < 40 && !st.out_almost_full) begin
            set_in(1'b1, 1'b1, 1'b1, 6'(n_sent), DW'(n_sent));
            n_sent++;
         end else begin
            set_in(1'b0, 1'b0, 1'b0, '0, '0);
         end
         if (st.out_valid && st.out_ready) begin
            total++;
            if (st.out_data !== DW'(n_recv) || st.out_empty !== 6'(n_recv)) begin
               bad++; $display("FAIL wrap_order: got data=%0d want %0d", st.out_data, n_recv);
            end
            n_recv++;
         end
         tick();
      end
      set_in(1'b0, 1'b0, 1'b0, '0, '0);
      total++;
      if (n_recv != 40 || drop_cnt !== 32'd0) begin
         bad++; $display("FAIL wrap_count: got recv=%0d drop=%0d want 40 0", n_recv, drop_cnt);
      end
   endtask

   task automatic test_framing();
      do_reset();
      st.out_ready = 1'b1;
      set_in(1'b1, 1'b1, 1'b0, '0, DW'(1));
      tick();
      set_in(1'b1, 1'b0, 1'b0, '0, DW'(2));
      tick();
      total++;
      if (framing_err !== 1'b0) begin
         bad++; $display("FAIL frame_ok: got ferr=%b want 0", framing_err);
      end
      set_in(1'b1, 1'b1, 1'b0, '0, DW'(3));
      tick();
      set_in(1'b0, 1'b0, 1'b0, '0, '0);
      total++;
      if (framing_err !== 1'b1 || st.out_data !== DW'(3) || st.out_valid !== 1'b1) begin
         bad++; $display("FAIL frame_double_sop: got ferr=%b v=%b data=%0d want 1 1 3", framing_err, st.out_valid, st.out_data);
      end
      do_reset();
      set_in(1'b1, 1'b0, 1'b1, '0, DW'(8'h77));
      tick();
      set_in(1'b0, 1'b0, 1'b0, '0, '0);
      total++;
      if (framing_err !== 1'b1 || st.out_valid !== 1'b1 || st.out_data !== DW'(8'h77)) begin
         bad++; $display("FAIL frame_no_sop: got ferr=%b v=%b data=%h want 1 1 77", framing_err, st.out_valid, st.out_data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      st.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, (i == 1), 1'b0, '0, rand_data());
         tick();
      end
      total++;
      if (occupancy !== 5'd5 || framing_err !== 1'b1) begin
         bad++; $display("FAIL mid_pre: got occ=%0d ferr=%b want 5 1", occupancy, framing_err);
      end
      rst = 1'b1;
      set_in(1'b1, 1'b0, 1'b0, '0, rand_data());
      tick();
      rst = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, '0, '0);
      total++;
      if ({st.out_valid, st.out_almost_full, overflow, framing_err} !== 4'b0 || occupancy !== 5'd0) begin
         bad++; $display("FAIL mid_reset: got v/af/ovf/ferr=%b occ=%0d want 0000 0",
                         {st.out_valid, st.out_almost_full, overflow, framing_err}, occupancy);
      end
      set_in(1'b1, 1'b1, 1'b0, '0, DW'(5));
      tick();
      set_in(1'b1, 1'b0, 1'b1, '0, DW'(6));
      tick();
      set_in(1'b0, 1'b0, 1'b0, '0, '0);
      total++;
      if (framing_err !== 1'b0 || occupancy !== 5'd2 || drop_cnt !== 32'd0) begin
         bad++; $display("FAIL mid_newpkt: got ferr=%b occ=%0d drop=%0d want 0 2 0", framing_err, occupancy, drop_cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         st.out_ready = ($urandom_range(0, 99) < 40);
         set_in(($urandom_range(0, 99) < 75), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), 6'($urandom), rand_data());
         total++;
         if (occupancy !== 5'(mq.size()) || st.out_valid !== (mq.size() != 0)) begin
            bad++; $display("FAIL rand_occ@%0d: got occ=%0d v=%b want %0d", cyc, occupancy, st.out_valid, mq.size());
         end
         if (mq.size() != 0) begin
            total++;
            if ({st.out_sop, st.out_eop, st.out_empty, st.out_data} !== mq[0]) begin
               bad++; $display("FAIL rand_head@%0d: got data=%h want %h", cyc, st.out_data, mq[0].data);
            end
         end
         total++;
         if ({st.out_almost_full, overflow, framing_err} !== {m_af, m_ovf, m_ferr}) begin
            bad++; $display("FAIL rand_flags@%0d: got af/ovf/ferr=%b want %b", cyc,
                            {st.out_almost_full, overflow, framing_err}, {m_af, m_ovf, m_ferr});
         end
         total++;
         if (drop_cnt !== m_drop) begin
            bad++; $display("FAIL rand_drop@%0d: got %0d want %0d", cyc, drop_cnt, m_drop);
         end
         tick();
      end
      set_in(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      rst = 1'b1;
      st.out_ready = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, '0, '0);
      test_reset();
      test_single_beat();
      test_almost_full();
      test_overflow();
      test_full_pop();
      test_wrap_order();
      test_framing();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
